// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipeline control tracker.
package ctrl_pkg;

  // Decoded control bundle carried from ID towards WB (9 bits).
  typedef struct packed {
    logic       RegDst;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
  } ctrl_t;

  // A bubble is an instruction with every control bit cleared.
  localparam ctrl_t BUBBLE = '0;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage bundle in, per-stage controls and hazard controls out.
interface ctrl_pipe_if #(parameter int REG_W = 5);
  logic             i_valid;
  logic             i_RegDst;
  logic             i_ALUSrc;
  logic             i_Branch;
  logic             i_MemRead;
  logic             i_MemWrite;
  logic             i_RegWrite;
  logic             i_MemtoReg;
  logic [1:0]       i_ALUOp;
  logic [REG_W-1:0] i_rs;
  logic [REG_W-1:0] i_rt;
  logic [REG_W-1:0] i_rd;
  logic             i_Zero;
  logic             o_ex_RegDst;
  logic             o_ex_ALUSrc;
  logic [1:0]       o_ex_ALUOp;
  logic             o_mem_MemRead;
  logic             o_mem_MemWrite;
  logic             o_wb_RegWrite;
  logic             o_wb_MemtoReg;
  logic [REG_W-1:0] o_wb_write_reg;
  logic [1:0]       o_ForwardA;
  logic [1:0]       o_ForwardB;
  logic             o_PCWrite;
  logic             o_IFIDWrite;
  logic             o_PCSrc;
  logic             o_IFIDFlush;

  // Core side: drives the ID bundle, consumes the stage controls.
  modport master (
    output i_valid, i_RegDst, i_ALUSrc, i_Branch, i_MemRead, i_MemWrite,
           i_RegWrite, i_MemtoReg, i_ALUOp, i_rs, i_rt, i_rd, i_Zero,
    input  o_ex_RegDst, o_ex_ALUSrc, o_ex_ALUOp, o_mem_MemRead, o_mem_MemWrite,
           o_wb_RegWrite, o_wb_MemtoReg, o_wb_write_reg, o_ForwardA, o_ForwardB,
           o_PCWrite, o_IFIDWrite, o_PCSrc, o_IFIDFlush
  );

  // Tracker side.
  modport slave (
    input  i_valid, i_RegDst, i_ALUSrc, i_Branch, i_MemRead, i_MemWrite,
           i_RegWrite, i_MemtoReg, i_ALUOp, i_rs, i_rt, i_rd, i_Zero,
    output o_ex_RegDst, o_ex_ALUSrc, o_ex_ALUOp, o_mem_MemRead, o_mem_MemWrite,
           o_wb_RegWrite, o_wb_MemtoReg, o_wb_write_reg, o_ForwardA, o_ForwardB,
           o_PCWrite, o_IFIDWrite, o_PCSrc, o_IFIDFlush
  );
endinterface

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational hazard unit: load-use stall, branch redirect, forwarding.
module hazard_fwd
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             exMemRead,
  input  logic             exBranch,
  input  logic [REG_W-1:0] exRs,
  input  logic [REG_W-1:0] exRt,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             zero,
  input  logic             memRegWrite,
  input  logic [REG_W-1:0] memDest,
  input  logic             wbRegWrite,
  input  logic [REG_W-1:0] wbDest,
  output logic             stall,
  output logic             pcSrc,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB
);

  // Nearest producer wins; $0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src,
                                        input logic memWr, input logic [REG_W-1:0] memD,
                                        input logic wbWr, input logic [REG_W-1:0] wbD);
    if (memWr && memD != '0 && memD == src)   return FWD_EXMEM;
    else if (wbWr && wbD != '0 && wbD == src) return FWD_MEMWB;
    else                                      return FWD_RF;
  endfunction

  // Redirect dominates a (theoretically impossible) simultaneous stall.
  always_comb begin
    pcSrc     = exBranch & zero;
    stall     = exMemRead & (exRt != '0) & idValid & ((exRt == idRs) | (exRt == idRt));
    pcWrite   = !(stall & !pcSrc);
    ifIdWrite = !(stall & !pcSrc);
    ifIdFlush = pcSrc;
    forwardA  = fwdSel(exRs, memRegWrite, memDest, wbRegWrite, wbDest);
    forwardB  = fwdSel(exRt, memRegWrite, memDest, wbRegWrite, wbDest);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the ID control bundle through ID/EX, EX/MEM and MEM/WB and
// presents each control in the stage that consumes it.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ctrl_pipe_if.slave bus
);

  ctrl_t            idCtrl;
  ctrl_t            exCtrl_p0;
  logic [REG_W-1:0] exRs_p0, exRt_p0, exRd_p0;
  logic             memMemRead_p1, memMemWrite_p1, memRegWrite_p1, memMemtoReg_p1;
  logic [REG_W-1:0] memDest_p1;
  logic             wbRegWrite_p2, wbMemtoReg_p2;
  logic [REG_W-1:0] wbDest_p2;
  logic [REG_W-1:0] exDest;
  logic             stall, pcSrc, injectBubble;

  // Pack the ID bundle and derive the EX destination and bubble request.
  always_comb begin
    idCtrl.RegDst   = bus.i_RegDst;
    idCtrl.ALUSrc   = bus.i_ALUSrc;
    idCtrl.ALUOp    = bus.i_ALUOp;
    idCtrl.Branch   = bus.i_Branch;
    idCtrl.MemRead  = bus.i_MemRead;
    idCtrl.MemWrite = bus.i_MemWrite;
    idCtrl.RegWrite = bus.i_RegWrite;
    idCtrl.MemtoReg = bus.i_MemtoReg;
    exDest          = exCtrl_p0.RegDst ? exRd_p0 : exRt_p0;
    injectBubble    = !bus.i_valid | stall | pcSrc;
  end

  hazard_fwd #(.REG_W(REG_W)) uHazard (
    .exMemRead   (exCtrl_p0.MemRead),
    .exBranch    (exCtrl_p0.Branch),
    .exRs        (exRs_p0),
    .exRt        (exRt_p0),
    .idValid     (bus.i_valid),
    .idRs        (bus.i_rs),
    .idRt        (bus.i_rt),
    .zero        (bus.i_Zero),
    .memRegWrite (memRegWrite_p1),
    .memDest     (memDest_p1),
    .wbRegWrite  (wbRegWrite_p2),
    .wbDest      (wbDest_p2),
    .stall       (stall),
    .pcSrc       (pcSrc),
    .pcWrite     (bus.o_PCWrite),
    .ifIdWrite   (bus.o_IFIDWrite),
    .ifIdFlush   (bus.o_IFIDFlush),
    .forwardA    (bus.o_ForwardA),
    .forwardB    (bus.o_ForwardB)
  );

  // Stage registers; bubbles also clear register fields so they never match.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      exCtrl_p0      <= BUBBLE;
      exRs_p0        <= '0;
      exRt_p0        <= '0;
      exRd_p0        <= '0;
      memMemRead_p1  <= 1'b0;
      memMemWrite_p1 <= 1'b0;
      memRegWrite_p1 <= 1'b0;
      memMemtoReg_p1 <= 1'b0;
      memDest_p1     <= '0;
      wbRegWrite_p2  <= 1'b0;
      wbMemtoReg_p2  <= 1'b0;
      wbDest_p2      <= '0;
    end else begin
      // ID/EX
      exCtrl_p0      <= injectBubble ? BUBBLE : idCtrl;
      exRs_p0        <= injectBubble ? '0 : bus.i_rs;
      exRt_p0        <= injectBubble ? '0 : bus.i_rt;
      exRd_p0        <= injectBubble ? '0 : bus.i_rd;
      // EX/MEM
      memMemRead_p1  <= exCtrl_p0.MemRead;
      memMemWrite_p1 <= exCtrl_p0.MemWrite;
      memRegWrite_p1 <= exCtrl_p0.RegWrite;
      memMemtoReg_p1 <= exCtrl_p0.MemtoReg;
      memDest_p1     <= exDest;
      // MEM/WB
      wbRegWrite_p2  <= memRegWrite_p1;
      wbMemtoReg_p2  <= memMemtoReg_p1;
      wbDest_p2      <= memDest_p1;
    end
  end

  // Present each stage's controls.
  always_comb begin
    bus.o_ex_RegDst    = exCtrl_p0.RegDst;
    bus.o_ex_ALUSrc    = exCtrl_p0.ALUSrc;
    bus.o_ex_ALUOp     = exCtrl_p0.ALUOp;
    bus.o_mem_MemRead  = memMemRead_p1;
    bus.o_mem_MemWrite = memMemWrite_p1;
    bus.o_wb_RegWrite  = wbRegWrite_p2;
    bus.o_wb_MemtoReg  = wbMemtoReg_p2;
    bus.o_wb_write_reg = wbDest_p2;
    bus.o_PCSrc        = pcSrc;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe against an instruction-level pipeline model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int REG_W = 5;

  typedef struct {
    bit       regDst, aluSrc;
    bit [1:0] aluOp;
    bit       branch, memRead, memWrite, regWrite, memtoReg;
    int       rs, rt, rd;
  } instr_t;

  typedef enum int { K_R, K_LW, K_SW, K_BEQ, K_ADDI } kind_e;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;
  instr_t pipe[3];     // 0 = EX, 1 = MEM, 2 = WB
  instr_t bubble;

  ctrl_pipe_if #(.REG_W(REG_W)) bus ();

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input kind_e k, input int rs, input int rt, input int rd);
    instr_t x;
    x = '{default: 0};
    x.rs = rs; x.rt = rt; x.rd = rd;
    case (k)
      K_R:    begin x.regDst = 1; x.aluOp = 2'b10; x.regWrite = 1; end
      K_LW:   begin x.aluSrc = 1; x.memRead = 1; x.regWrite = 1; x.memtoReg = 1; end
      K_SW:   begin x.aluSrc = 1; x.memWrite = 1; end
      K_BEQ:  begin x.aluOp = 2'b01; x.branch = 1; end
      default: begin x.aluSrc = 1; x.regWrite = 1; end
    endcase
    return x;
  endfunction

  // Register an instruction writes (0 when it writes nothing).
  function automatic int writes(input instr_t x);
    if (!x.regWrite) return 0;
    return x.regDst ? x.rd : x.rt;
  endfunction

  function automatic int destOf(input instr_t x);
    return x.regDst ? x.rd : x.rt;
  endfunction

  // Which older in-flight instruction supplies a source operand.
  function automatic int fwdFor(input int src);
    if (src != 0 && writes(pipe[1]) == src) return 2;
    if (src != 0 && writes(pipe[2]) == src) return 1;
    return 0;
  endfunction

  // One clock: present inputs, check outputs, advance the model.
  task automatic step(input instr_t ins, input bit valid, input bit zero,
                      input bit rstn, output bit held);
    bit takeBr, loadUse, hold;
    bus.i_valid    = valid;
    bus.i_RegDst   = ins.regDst;
    bus.i_ALUSrc   = ins.aluSrc;
    bus.i_ALUOp    = ins.aluOp;
    bus.i_Branch   = ins.branch;
    bus.i_MemRead  = ins.memRead;
    bus.i_MemWrite = ins.memWrite;
    bus.i_RegWrite = ins.regWrite;
    bus.i_MemtoReg = ins.memtoReg;
    bus.i_rs       = REG_W'(ins.rs);
    bus.i_rt       = REG_W'(ins.rt);
    bus.i_rd       = REG_W'(ins.rd);
    bus.i_Zero     = zero;
    rstN           = rstn;
    @(negedge clk);
    takeBr  = pipe[0].branch && zero;
    loadUse = valid && pipe[0].memRead && pipe[0].rt != 0 &&
              (pipe[0].rt == ins.rs || pipe[0].rt == ins.rt);
    hold    = loadUse && !takeBr;
    chk("ex_RegDst",  bus.o_ex_RegDst,    pipe[0].regDst);
    chk("ex_ALUSrc",  bus.o_ex_ALUSrc,    pipe[0].aluSrc);
    chk("ex_ALUOp",   bus.o_ex_ALUOp,     pipe[0].aluOp);
    chk("mem_MemRd",  bus.o_mem_MemRead,  pipe[1].memRead);
    chk("mem_MemWr",  bus.o_mem_MemWrite, pipe[1].memWrite);
    chk("wb_RegWr",   bus.o_wb_RegWrite,  pipe[2].regWrite);
    chk("wb_MemtoR",  bus.o_wb_MemtoReg,  pipe[2].memtoReg);
    chk("wb_reg",     bus.o_wb_write_reg, destOf(pipe[2]));
    chk("ForwardA",   bus.o_ForwardA,     fwdFor(pipe[0].rs));
    chk("ForwardB",   bus.o_ForwardB,     fwdFor(pipe[0].rt));
    chk("PCWrite",    bus.o_PCWrite,      !hold);
    chk("IFIDWrite",  bus.o_IFIDWrite,    !hold);
    chk("PCSrc",      bus.o_PCSrc,        takeBr);
    chk("IFIDFlush",  bus.o_IFIDFlush,    takeBr);
    @(posedge clk);
    #1;
    if (!rstn) begin
      pipe[0] = bubble; pipe[1] = bubble; pipe[2] = bubble;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (!valid || loadUse || takeBr) ? bubble : ins;
    end
    held = hold && rstn;
  endtask

  // Issue one instruction, re-presenting it while IF/ID is held.
  task automatic issue(input instr_t ins, input bit zero);
    bit st;
    int n = 0;
    do begin
      step(ins, 1'b1, zero, 1'b1, st);
      n++;
    end while (st && n < 4);
    chk("stall_len", (n < 3), 1);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) step(bubble, 1'b0, 1'b0, 1'b1, st);
  endtask

  initial begin
    bit     st, held, v, z, r;
    instr_t cur;
    bubble = '{default: 0};
    pipe[0] = bubble; pipe[1] = bubble; pipe[2] = bubble;
    // Reset without checking: state before the first edge is unknown.
    rstN = 1'b0;
    bus.i_valid = 0; bus.i_RegDst = 0; bus.i_ALUSrc = 0; bus.i_ALUOp = 0;
    bus.i_Branch = 0; bus.i_MemRead = 0; bus.i_MemWrite = 0; bus.i_RegWrite = 0;
    bus.i_MemtoReg = 0; bus.i_rs = 0; bus.i_rt = 0; bus.i_rd = 0; bus.i_Zero = 0;
    @(posedge clk);
    #1;
    step(bubble, 1'b0, 1'b0, 1'b0, st);

    // R-type propagation
    issue(mk(K_R, 1, 2, 5), 0);
    idle(4);
    // Back-to-back, one-apart, and double-producer forwarding
    issue(mk(K_R, 1, 2, 3), 0);  issue(mk(K_R, 3, 6, 8), 0);  idle(3);
    issue(mk(K_R, 1, 2, 3), 0);  issue(mk(K_ADDI, 1, 7, 0), 0);
    issue(mk(K_R, 3, 6, 8), 0);  idle(3);
    issue(mk(K_R, 1, 2, 3), 0);  issue(mk(K_R, 4, 5, 3), 0);
    issue(mk(K_R, 3, 3, 9), 0);  idle(3);
    // Load-use and the $0 guard
    issue(mk(K_LW, 1, 4, 0), 0); issue(mk(K_R, 4, 2, 6), 0);  idle(3);
    issue(mk(K_LW, 1, 0, 0), 0); issue(mk(K_R, 0, 0, 6), 0);  idle(3);
    // Branch taken / not taken
    issue(mk(K_BEQ, 1, 2, 0), 0); issue(mk(K_R, 1, 2, 7), 1); idle(2);
    issue(mk(K_BEQ, 1, 2, 0), 0); issue(mk(K_R, 1, 2, 7), 0); idle(3);
    // Reset while a store sits in MEM
    issue(mk(K_SW, 1, 2, 0), 0); issue(mk(K_R, 1, 2, 3), 0);
    step(mk(K_R, 3, 3, 4), 1'b1, 1'b0, 1'b0, st);
    idle(1);

    // Randomized traffic with a held IF/ID across stalls
    held = 0;
    cur  = bubble;
    for (int i = 0; i < 1500; i++) begin
      if (!held) begin
        cur = mk(kind_e'($urandom_range(4, 0)), $urandom_range(7, 0),
                 $urandom_range(7, 0), $urandom_range(7, 0));
        v = ($urandom_range(7, 0) != 0);
      end else begin
        v = 1;
      end
      z = $urandom_range(1, 0);
      r = ($urandom_range(63, 0) != 0);
      step(cur, v, z, r, held);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline control tracker and hazard unit for the 5-stage MIPS core. Consumes the decoded control bundle and register fields from the ID stage, carries the bundle through the ID/EX, EX/MEM and MEM/WB stage registers, and presents each control bit in the stage that uses it. It also resolves hazards. It stalls IF/ID on load-use, drives forwarding selects from EX/MEM and MEM/WB, and flushes the pipeline on a taken `beq` resolved in EX.

## Interface
Parameters:
- `REG_W`, 5, register index width.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_valid` in 1: the IF/ID instruction is real. 0 injects a bubble.
- `i_RegDst`, `i_ALUSrc`, `i_Branch`, `i_MemRead`, `i_MemWrite`, `i_RegWrite`, `i_MemtoReg` in 1 each: ID control bundle.
- `i_ALUOp` in 2: ID control bundle.
- `i_rs`, `i_rt`, `i_rd` in `REG_W`: IF/ID register fields.
- `i_Zero` in 1: ALU zero flag of the instruction currently in EX.
- `o_ex_RegDst`, `o_ex_ALUSrc` out 1: EX-stage controls.
- `o_ex_ALUOp` out 2: EX-stage control.
- `o_mem_MemRead`, `o_mem_MemWrite` out 1: MEM-stage controls.
- `o_wb_RegWrite`, `o_wb_MemtoReg` out 1: WB-stage controls.
- `o_wb_write_reg` out `REG_W`: WB destination register.
- `o_ForwardA`, `o_ForwardB` out 2: EX operand selects. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- `o_PCWrite`, `o_IFIDWrite` out 1: 0 holds the PC and IF/ID.
- `o_PCSrc` out 1: take the branch target.
- `o_IFIDFlush` out 1: zero IF/ID on the next edge.

## Operation
- **ID/EX register** holds the 9 control bits plus `rs`, `rt`, `rd`.
  - Captures a bubble (all controls 0) when `!i_valid`, on load-use stall, or on `o_PCSrc`.
  - Otherwise captures the ID inputs.
- **EX destination**: `ex_dest = ex_RegDst ? ex_rd : ex_rt`.
- **EX/MEM register** captures `MemRead`, `MemWrite`, `RegWrite`, `MemtoReg` and `ex_dest`.
- **MEM/WB register** captures `RegWrite`, `MemtoReg` and the destination.
- **Branch**: `o_PCSrc = ex_Branch & i_Zero`, combinational. When it is set:
  - `o_IFIDFlush = 1`.
  - The next ID/EX is a bubble.
  - The EX instruction itself proceeds; a `beq` carries no write.
- **Load-use stall**: `stall = ex_MemRead & (ex_rt != 0) & i_valid & ((ex_rt == i_rs) | (ex_rt == i_rt))`. When it is set:
  - `o_PCWrite = 0` and `o_IFIDWrite = 0`.
  - ID/EX receives a bubble.
  - Otherwise both write enables are 1.
- **Forwarding A**, using `ex_rs`:
  - 10 if `mem_RegWrite & mem_dest != 0 & mem_dest == ex_rs`.
  - Else 01 if `wb_RegWrite & wb_dest != 0 & wb_dest == ex_rs`.
  - Else 00.
- **Forwarding B** is the same with `ex_rt`.
- **Precedence and boundaries**:
  - EX/MEM beats MEM/WB when both match.
  - Register 0 is never forwarded and never causes a stall.
  - A stall and `o_PCSrc` cannot coincide, since EX holds one instruction that is either a load or a branch. If both are somehow set, `o_PCSrc` wins and `o_PCWrite` is 1.
  - A stall lasts exactly one cycle: the next cycle EX holds a bubble with `MemRead = 0`.

## Timing
- **Reset** (`!i_rst_n` sampled at an edge):
  - All three stage registers clear to bubble with destination 0.
  - Outputs after reset: `o_PCWrite = 1`, `o_IFIDWrite = 1`. All other outputs are 0.
  - Reset mid-stall or mid-branch discards all in-flight instructions.
- **Control latency**: one ID control bit appears on its `o_ex_*` output 1 cycle after it is presented, on `o_mem_*` after 2 cycles, and on `o_wb_*` after 3 cycles.
- **Combinational outputs**: `o_PCSrc`, `o_IFIDFlush`, `o_PCWrite`, `o_IFIDWrite` and `o_Forward*` are combinational from current stage state and inputs, valid in the same cycle.

## Structure
- A shared package `ctrl_pkg` holds:
  - the control-bundle struct (9 bits);
  - the bubble constant;
  - the forward-select encodings `FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`.
- One sub-module, `hazard_fwd`: purely combinational stall, forwarding and PCSrc logic. `ctrl_pipe` keeps the stage registers.

## Test plan
- **R-type propagation**: R-type bundle (`RegDst=1`, `RegWrite=1`, `ALUOp=10`) with `rd=5` -> `o_ex_ALUOp=10` at +1 cycle; `o_wb_RegWrite=1` and `o_wb_write_reg=5` at +3 cycles.
- **Back-to-back forwarding**:
  - `add $3` followed by `sub` using `rs=3` -> `o_ForwardA=10` while `sub` is in EX.
  - With one unrelated instruction between them -> `o_ForwardA=01`.
  - With `$3` written in both EX/MEM and MEM/WB -> `10`.
- **Load-use**: `lw rt=4` then `add rs=4` -> one cycle with `o_PCWrite=0`, `o_IFIDWrite=0`; `o_ex_*` is a bubble the next cycle; then `o_ForwardA=01`.
- **Register 0 guard**: `lw rt=0` then `add rs=0` -> no stall, and `o_ForwardA=00`.
- **Branch**: `beq` in EX with `i_Zero=1` -> `o_PCSrc=1`, `o_IFIDFlush=1` that cycle; next `o_ex_*` is all 0. With `i_Zero=0` -> no flush.
- **Reset**: drive `i_rst_n=0` mid-pipeline with a `sw` in MEM -> after the edge `o_mem_MemWrite=0`, `o_PCWrite=1`, and all stage outputs are 0.
